// File: rtl/y_adder.sv
// Registered WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// Optional macro YADDER_OVF_EN adds a registered signed-overflow output `ovf`.

module y_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module y_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef YADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the top bit.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        y_adder_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // out_valid follows in_valid every cycle, so it is a one-cycle pulse per
    // accepted operand set; the data registers only load on accepted cycles.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, regardless of statement order or block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z    <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef YADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_y_adder.sv
// Self-checking bench for y_adder (WIDTH=32): table vectors plus reset,
// streaming and hold sequences. Checks ovf when built with YADDER_OVF_EN.

module tb_y_adder;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] z;
    logic         cout;
`ifdef YADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    y_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .z         (z),
        .cout      (cout)
`ifdef YADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_z;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    logic [W-1:0] ra[10];
    logic [W-1:0] rb[10];
    logic [W:0]   rexp;
    logic [W-1:0] held_z;
    logic         held_cout;

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_z", 64'(z), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
`ifdef YADDER_OVF_EN
        check("reset_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load z=0xFFFFFFFF, then assert reset mid-cycle and look before the next edge.
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = '0; cin = 1'b0;
        step();
        in_valid = 1'b0;
        check("preload_z", 64'(z), 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_z", 64'(z), 64'd0);
        check("async_rst_cout", 64'(cout), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table vectors: one accepted cycle, then one idle cycle.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            step();
            in_valid = 1'b0; a = ~a; b = ~b; cin = ~cin;
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_z", i), 64'(z), 64'(vecs[i].exp_z));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].exp_cout));
`ifdef YADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
`endif
            step();
            check($sformatf("vec%0d_idle_out_valid", i), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d_idle_z", i), 64'(z), 64'(vecs[i].exp_z));
            check($sformatf("vec%0d_idle_cout", i), 64'(cout), 64'(vecs[i].exp_cout));
        end

        // Back-to-back random stream, checked one cycle after presentation.
        for (int i = 0; i < 10; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        cin = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                in_valid = 1'b1; a = ra[i]; b = rb[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            rexp = {1'b0, ra[i < 10 ? i : 9]} + {1'b0, rb[i < 10 ? i : 9]};
            if (i < 10) begin
                check($sformatf("stream%0d_out_valid", i), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d_z", i), 64'(z), 64'(rexp[W-1:0]));
                check($sformatf("stream%0d_cout", i), 64'(cout), 64'(rexp[W]));
            end
        end
        check("stream_end_out_valid", 64'(out_valid), 64'd0);

        // Hold: operands toggle with in_valid low; outputs must not move.
        held_z    = rexp[W-1:0];
        held_cout = rexp[W];
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            step();
            check($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd0);
            check($sformatf("hold%0d_z", i), 64'(z), 64'(held_z));
            check($sformatf("hold%0d_cout", i), 64'(cout), 64'(held_cout));
        end

        // Reset falling in the capture cycle discards the result.
        in_valid = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_z", 64'(z), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        step();
        check("midrst_hold_z", 64'(z), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y_adder.md
Name: y_adder

Overview:
- Clocked WIDTH-bit ripple-carry adder. Computes z = a + b + cin and produces a carry-out.
- The datapath is a chain of WIDTH 1-bit full-adder cells. Carry ripples from bit 0 upward.
- The sum and carry are captured in an output register with a valid flag.
- Serves as the integer add primitive for the lab ALU datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in to bit 0
- out_valid  output  1  z/cout hold a freshly captured result
- z  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Reset: rst_n low asynchronously clears z, cout and out_valid to 0 immediately, without waiting for a clock edge. Reset release is sampled on the next rising clk edge.
- Combinational core, per bit i:
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
  - c[0] = cin
  - Core carry-out = c[WIDTH].
- The core must be built from instantiated 1-bit full-adder cells in a generate loop. The bit-level result must equal the arithmetic WIDTH+1-bit sum {cout,z} = a + b + cin.
- Capture: on a rising clk edge with in_valid=1, z and cout load the core outputs and out_valid is set to 1. Latency is exactly 1 cycle from operand presentation to out_valid.
- Idle: on a rising clk edge with in_valid=0, z and cout hold their previous values and out_valid goes to 0. out_valid is therefore a one-cycle pulse per accepted operand set.
- Back-to-back: in_valid high on consecutive cycles gives one result per cycle. out_valid stays high continuously.
- No backpressure. Results are not queued. The consumer must sample the output in the out_valid cycle.
- Wrap-around: the sum is truncated to WIDTH bits. Overflow of unsigned addition is signalled only by cout.
- Operands are don't-care when in_valid=0. Toggling them must not change z or cout.
- Reset mid-operation: a result being captured in the same cycle rst_n falls is discarded. Outputs read 0 and out_valid=0 until the next accepted input.
- X/Z on a, b or cin while in_valid=1 may propagate to z and cout. out_valid itself is never X after reset.

Optional Feature:
- Macro YADDER_OVF_EN.
- When defined: adds output port ovf (1 bit, registered alongside z). ovf is the two's-complement signed overflow, c[WIDTH] ^ c[WIDTH-1]. It resets to 0 and holds when in_valid=0.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with prior z=0xFFFFFFFF -> z=0, cout=0, out_valid=0 immediately, before the next clk edge.
- Basic add: a=0x00000005, b=0x00000003, cin=0, in_valid=1 for one cycle -> next cycle z=0x00000008, cout=0, out_valid=1. The cycle after: out_valid=0, z still 0x00000008.
- Carry-in and wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 -> z=0x00000000, cout=1. Then a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> z=0xFFFFFFFF, cout=1.
- Full ripple: a=0x7FFFFFFF, b=0x00000001, cin=0 -> z=0x80000000, cout=0. With YADDER_OVF_EN also ovf=1. Then a=0x80000000, b=0x80000000 -> z=0, cout=1, ovf=1.
- Random streaming: 10 back-to-back random a/b pairs with cin=0 and in_valid held high.
  - Each result must match expect = a+b one cycle later.
  - out_valid must stay continuously 1.
- Hold: in_valid=0 while a/b toggle randomly for 5 cycles -> z and cout unchanged, out_valid=0 throughout.
